snek_matrix_scan: RTL

Display-side consumer of the snake game's 12×9 occupancy map. Each frame it snapshots the map, then scans it row by row into an external LED matrix built from a serial-in/parallel-out column shift register plus a row decoder. It sits between the movement logic's `map` output and the board pins, and owns all display timing.

---
 rtl/snek_matrix_scan.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/snek_matrix_scan.sv
// snek_matrix_scan
//   Display-side scanner for the snake game's 12x9 occupancy map. Once per
//   frame it snapshots map_flat, then for each row y = 0..8 shifts 12 column
//   bits (x = 11 first, x = 0 last) into an external SIPO shift register. It
//   then latches the register outputs and lights the row for HOLD_CYCLES
//   cycles. The matrix is blanked (row_en = 0) while a row is being shifted
//   or latched.
//
// Parameters
//   CLK_DIV      half-period of ser_clk in clk cycles (>= 1)
//   HOLD_CYCLES  cycles each row stays lit (>= 1)
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   enable      level; starts scanning and is sampled again only at frame end
//   map_flat    occupancy map, bit x*9+y = cell (x,y)
//   ser_data    column bit to the shift register
//   ser_clk     shift clock (the register samples on its rising edge)
//   ser_latch   parallel-load strobe for the shift register outputs
//   row_sel     displayed row index, 0..8
//   row_en      row driver enable, low = blanked
//   frame_done  one-cycle pulse after the hold phase of row 8
//   busy        high in every state except IDLE
//
// Handshake: there is none. enable is a plain level. It is sampled in IDLE
// and at the end of each frame only. All outputs are registered.

module snek_matrix_scan #(
    parameter int CLK_DIV     = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [107:0] map_flat,
    output logic         ser_data,
    output logic         ser_clk,
    output logic         ser_latch,
    output logic [3:0]   row_sel,
    output logic         row_en,
    output logic         frame_done,
    output logic         busy
);

    localparam int MAX_CNT = (CLK_DIV > HOLD_CYCLES) ? CLK_DIV : HOLD_CYCLES;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH,
        HOLD
    } scanState_e;

    scanState_e      state;
    logic [107:0]    snapshot;
    logic [3:0]      rowY;     // row being shifted/shown, 0..8
    logic [3:0]      bitIdx;   // column x being shifted, counts 11 down to 0
    logic [CW-1:0]   divCnt;   // shared by the ser_clk halves, LATCH and HOLD

    function automatic logic snapBit(input logic [107:0] s,
                                     input logic [3:0] cx,
                                     input logic [3:0] cy);
        logic [6:0] idx;
        idx = 7'(cx) * 7'd9 + 7'(cy);
        return s[idx];
    endfunction

    // Every output is set on the edge that enters the state in which it
    // must be visible. That keeps all outputs registered and still meets the
    // cycle counts measured from the LOAD edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            snapshot   <= '0;
            rowY       <= '0;
            bitIdx     <= '0;
            divCnt     <= '0;
            ser_data   <= 1'b0;
            ser_clk    <= 1'b0;
            ser_latch  <= 1'b0;
            row_sel    <= '0;
            row_en     <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end

                LOAD: begin
                    snapshot <= map_flat;
                    rowY     <= 4'd0;
                    bitIdx   <= 4'd11;
                    divCnt   <= '0;
                    ser_clk  <= 1'b0;
                    // The snapshot is being written on this same edge, so the
                    // first bit, cell (11,0), comes straight from the input.
                    ser_data <= map_flat[99];
                    state    <= SHIFT;
                end

                SHIFT: begin
                    if (divCnt == DIV_LAST) begin
                        divCnt <= '0;
                        if (!ser_clk) begin
                            ser_clk <= 1'b1;
                        end else if (bitIdx == 4'd0) begin
                            ser_clk   <= 1'b0;
                            ser_data  <= 1'b0;
                            ser_latch <= 1'b1;
                            row_sel   <= rowY;
                            state     <= LATCH;
                        end else begin
                            // Falling edge of ser_clk: the only point where
                            // ser_data moves inside a row.
                            ser_clk  <= 1'b0;
                            bitIdx   <= bitIdx - 4'd1;
                            ser_data <= snapBit(snapshot, bitIdx - 4'd1, rowY);
                        end
                    end else begin
                        divCnt <= divCnt + CW'(1);
                    end
                end

                LATCH: begin
                    if (divCnt == DIV_LAST) begin
                        divCnt    <= '0;
                        ser_latch <= 1'b0;
                        row_en    <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        divCnt <= divCnt + CW'(1);
                    end
                end

                HOLD: begin
                    if (divCnt == HOLD_LAST) begin
                        divCnt <= '0;
                        row_en <= 1'b0;
                        if (rowY != 4'd8) begin
                            rowY     <= rowY + 4'd1;
                            bitIdx   <= 4'd11;
                            ser_data <= snapBit(snapshot, 4'd11, rowY + 4'd1);
                            state    <= SHIFT;
                        end else begin
                            frame_done <= 1'b1;
                            if (enable) begin
                                state <= LOAD;
                            end else begin
                                state   <= IDLE;
                                busy    <= 1'b0;
                                row_sel <= 4'd0;
                            end
                        end
                    end else begin
                        divCnt <= divCnt + CW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
